// File: rtl/fp_accumulator.sv
// ============================================================================
// Module   : fp_accumulator
// Purpose  : Sequential float32 accumulator wrapped around an external
//            combinational single-precision adder. It feeds the adder from
//            its own registers (add_a = accumulator, add_b = latched element)
//            and captures the adder result. It reduces one valid/ready packet
//            of float32 elements, terminated by in_last, into a sum and an
//            element count. The result is returned on a valid/ready port.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready/in_data/in_last  - element stream
//            add_a/add_b -> adder, add_result <- adder (combinational)
//            out_valid/out_ready/out_sum/out_count - packet result
//            busy - high in every state except IDLE
// Options  : FP_ACC_ZERO_BYPASS_EN - bypasses the adder when either operand
//            is +/-0, because the adder always inserts the hidden bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   input  logic [31:0]      add_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_ADD   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [31:0]      acc_q,   acc_d;
   logic [31:0]      b_q,     b_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             last_q,  last_d;

   logic             w_accept;
   logic             w_take;
   logic [31:0]      w_sum_sel;

   // ------------------------------------------------------------------------
   // Result selection
   // ------------------------------------------------------------------------
`ifdef FP_ACC_ZERO_BYPASS_EN
   // Sign bit is ignored: +0 and -0 are both treated as zero.
   always_comb begin
      w_sum_sel = add_result;
      if (b_q[30:0] == 31'd0) begin
         w_sum_sel = acc_q;
      end else if (acc_q[30:0] == 31'd0) begin
         w_sum_sel = b_q;
      end
   end
`else
   assign w_sum_sel = add_result;
`endif

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= 32'd0;
         b_q     <= 32'd0;
         count_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath update
   // ------------------------------------------------------------------------
   assign w_accept = in_valid && in_ready;
   assign w_take   = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      b_d     = b_q;
      count_d = count_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               acc_d   = in_data;
               count_d = CNT_W'(1);
               last_d  = in_last;
               state_d = in_last ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_accept) begin
               b_d     = in_data;
               last_d  = in_last;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            // The adder sees acc_q/b_q this cycle; its result is captured here.
            acc_d = w_sum_sel;
            if (count_q != C_CNT_MAX) begin
               count_d = count_q + CNT_W'(1);
            end
            state_d = last_q ? S_DONE : S_ACCUM;
         end
         default: begin // S_DONE
            if (w_take) begin
               acc_d   = 32'd0;
               b_d     = 32'd0;
               count_d = '0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      // in_ready is forced low while reset is held, independent of state.
      in_ready  = rst_n && ((state_q == S_IDLE) || (state_q == S_ACCUM));
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      add_a     = acc_q;
      add_b     = b_q;
      out_sum   = acc_q;
      out_count = count_q;
   end

endmodule

`default_nettype wire

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential float32 accumulator that sits on both sides of the combinational single-precision adder: it issues the adder's A/B operands from its own registers and captures the adder's result. It takes a valid/ready stream of IEEE-754 single-precision values terminated by a `last` flag. It returns the running sum and the element count on a valid/ready output port. It is the reduction stage for dot-product and summation datapaths in the processing unit.

## Interface
- `CNT_W`, default 8: width of the element counter and of `out_count`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input element present.
- `in_ready`  out  1  block accepts an element this cycle.
- `in_data`  in  32  float32 element.
- `in_last`  in  1  element is the final one of the packet.
- `add_a`  out  32  adder operand A (registered accumulator).
- `add_b`  out  32  adder operand B (registered element).
- `add_result`  in  32  adder sum, combinational from `add_a`/`add_b`.
- `out_valid`  out  1  packet sum available.
- `out_ready`  in  1  consumer takes the sum.
- `out_sum`  out  32  accumulated float32 sum.
- `out_count`  out  CNT_W  elements in packet, saturating.
- `busy`  out  1  high in every state except IDLE.

## Operation
- An element is accepted when `in_valid && in_ready` at a rising edge.
- The sum is taken when `out_valid && out_ready` at a rising edge.
- States and transitions:
  - IDLE: `in_ready`=1.
    - On accept: `acc<=in_data`, `count<=1`, `last_r<=in_last`.
    - Go to DONE if `in_last`, else to ACCUM.
  - ACCUM: `in_ready`=1.
    - On accept: `b_reg<=in_data`, `last_r<=in_last`, go to ADD.
    - With no accept, stay in ACCUM.
  - ADD: `in_ready`=0.
    - `acc<=sum_sel`; `count<=count+1`, saturating at 2^CNT_W-1.
    - Go to DONE if `last_r`, else to ACCUM.
  - DONE: `in_ready`=0, `out_valid`=1.
    - On take: go to IDLE; `acc`, `count` and `b_reg` clear to 0.
- Outputs: `add_a`=`acc`, `add_b`=`b_reg`, `out_sum`=`acc`, `out_count`=`count`, all registered.
- `sum_sel` is `add_result`, except where the zero bypass applies (see Configuration).
- `in_data` is not inspected for NaN or Inf; it is passed to the adder unchanged.
- `in_last` is ignored unless the element is accepted.

## Timing
- Reset (async assert, sync deassert by the surrounding design): state=IDLE; `acc`, `b_reg`, `count` and `last_r` are 0.
  - `in_ready` is gated low while `rst_n`=0.
  - Reset values: `out_valid`=0, `out_sum`=0, `out_count`=0, `add_a`=0, `add_b`=0, `busy`=0.
- Single-element packet accepted in cycle N: `out_valid`=1 from cycle N+1.
- An element accepted in ACCUM in cycle k:
  - The adder sees it in cycle k+1.
  - `acc` updates at the end of cycle k+1.
  - `in_ready` returns high in cycle k+2, or `out_valid` rises in cycle k+2 if the element was last.
- Peak throughput is one element per 2 cycles after the first element.
- Packet latency from the last element accepted to `out_valid` is 2 cycles, or 1 cycle for a single-element packet.
- `out_valid`, `out_sum` and `out_count` hold stable until taken; with `out_ready` low the block stalls in DONE indefinitely.
- There is no input/output overlap: the next packet's first element is accepted no earlier than the cycle after the take.
- Reset asserted in any state, including mid-ADD or DONE, aborts the packet immediately. No partial sum is emitted.
- Counter saturation does not affect the sum; accumulation continues.

## Configuration
- `FP_ACC_ZERO_BYPASS_EN` defined: `sum_sel` is chosen as follows.
  - If `b_reg[30:0]`==0, `sum_sel`=`acc`.
  - Else if `acc[30:0]`==0, `sum_sel`=`b_reg`.
  - Otherwise `sum_sel`=`add_result`.
  - Reason: the adder always inserts the hidden bit, so it mis-adds ±0.
- Not defined: `sum_sel`=`add_result` always. Zero operands then go through the adder unchanged.

## Test plan
- Packet 1.0 (0x3F800000), 2.0 (0x40000000), 3.0 (0x40400000 with last) -> `out_sum`=0x40C00000, `out_count`=3, `out_valid` 2 cycles after the last accept.
- Single element 0x3F800000 with `in_last` -> `out_valid` the next cycle, `out_sum`=0x3F800000, `out_count`=1.
- Packet 2.0, -2.0 (0xC0000000, last) -> `out_sum`=0x00000000, `out_count`=2.
- With `FP_ACC_ZERO_BYPASS_EN`: packet 0.0, 5.0 (0x40A00000, last) -> `out_sum`=0x40A00000. Without the macro, `out_sum` equals the adder output.
- Backpressure: hold `out_ready` low 5 cycles after `out_valid` -> `out_sum` and `out_valid` stable, `in_ready`=0. Raise `out_ready` -> `busy`=0 and `in_ready`=1 the next cycle.
- Drive `rst_n` low during ADD of a 4-element packet -> all outputs 0 in the same cycle. A following 1.0+1.0 packet yields 0x40000000, `out_count`=2.
